scalar_alu_arbiter: RTL

// - Shares one combinational scalar ALU (with its N/Z/C/V flag logic) between two requesters.
// - Requester 0 is the scalar pipeline; requester 1 is the vector address/control unit.
// - Round-robin arbitration, operand registering, fixed-latency result capture.
// - Holds the response under a valid/ready handshake and maintains the architectural flag register.

---
 rtl/scalar_alu_arbiter_if.sv | 52 +++++
 rtl/scalar_alu_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/scalar_alu_arbiter_if.sv
// Bus bundle for the shared scalar ALU arbiter: two requester ports,
// the operand/result path to the external ALU, the response channel
// and the architectural flag register with its clear input.
interface scalar_alu_arbiter_if #(
  parameter int W = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [2:0]   req0_sel;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [2:0]   req1_sel;

  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_sel;
  logic [W-1:0] alu_res;
  logic [3:0]   alu_flags;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_res;

  logic [3:0]   flags_q;
  logic         flag_clr;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  alu_res, alu_flags, rsp_ready, flag_clr,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_res, flags_q
  );

  // Requesters, ALU and response consumer side
  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output alu_res, alu_flags, rsp_ready, flag_clr,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_res, flags_q
  );
endinterface

// File: rtl/scalar_alu_arbiter.sv
// Round-robin arbiter sharing one combinational scalar ALU between the
// scalar pipeline (requester 0) and the vector address/control unit
// (requester 1). One operation is in flight at a time: operands are
// registered on accept, the result is sampled ALU_LAT cycles later and
// held under a valid/ready handshake, and the {N,Z,C,V} register is
// loaded at the same moment.
// Optional build macro: STICKY_OVERFLOW_EN makes V accumulate across
// operations until flag_clr or reset.
module scalar_alu_arbiter #(
  parameter int W       = 32,
  parameter int ALU_LAT = 1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  scalar_alu_arbiter_if.slave bus
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           rrPtr_q, rrPtr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ownerId_q, ownerId_d;
  logic [W-1:0]   aluA_q, aluA_d;
  logic [W-1:0]   aluB_q, aluB_d;
  logic [2:0]     aluSel_q, aluSel_d;
  logic           rspValid_q, rspValid_d;
  logic [W-1:0]   rspRes_q, rspRes_d;
  logic [3:0]     flagReg_q, flagReg_d;

  logic           anyValid;
  logic           grantId;
  logic           accept;
  logic           capture;
  logic           handshake;

  // Grant decode: a lone requester always wins, a tie goes to rrPtr
  always_comb begin
    anyValid  = bus.req0_valid | bus.req1_valid;
    grantId   = (bus.req0_valid && bus.req1_valid) ? rrPtr_q : bus.req1_valid;
    accept    = (state_q == IDLE) && anyValid;
    capture   = (state_q == EXEC) && (cnt_q == '0);
    handshake = (state_q == RESP) && bus.rsp_ready;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (anyValid)  state_d = EXEC;
      EXEC:    if (capture)   state_d = RESP;
      RESP:    if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready goes only to the granted requester, and never while in reset
  always_comb begin
    bus.req0_ready = rst_ni && accept && !grantId;
    bus.req1_ready = rst_ni && accept &&  grantId;
  end

  // Datapath next-state: operand latch, latency count, result and flag capture
  always_comb begin
    rrPtr_d    = rrPtr_q;
    cnt_d      = cnt_q;
    ownerId_d  = ownerId_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluSel_d   = aluSel_q;
    rspValid_d = rspValid_q;
    rspRes_d   = rspRes_q;
    flagReg_d  = flagReg_q;

    if (accept) begin
      ownerId_d = grantId;
      rrPtr_d   = ~grantId;
      cnt_d     = CW'(ALU_LAT - 1);
      aluA_d    = grantId ? bus.req1_a   : bus.req0_a;
      aluB_d    = grantId ? bus.req1_b   : bus.req0_b;
      aluSel_d  = grantId ? bus.req1_sel : bus.req0_sel;
    end

    if ((state_q == EXEC) && !capture) begin
      cnt_d = cnt_q - CW'(1);
    end

    if (capture) begin
      rspRes_d   = bus.alu_res;
      rspValid_d = 1'b1;
    end else if (handshake) begin
      rspValid_d = 1'b0;
    end

    if (capture) begin
      flagReg_d = bus.alu_flags;
`ifdef STICKY_OVERFLOW_EN
      flagReg_d[0] = bus.alu_flags[0] | (flagReg_q[0] & ~bus.flag_clr);
`else
      flagReg_d[0] = bus.alu_flags[0];
`endif
    end else if (bus.flag_clr) begin
      flagReg_d = '0;
    end
  end

  // Datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rrPtr_q    <= 1'b0;
      cnt_q      <= '0;
      ownerId_q  <= 1'b0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluSel_q   <= '0;
      rspValid_q <= 1'b0;
      rspRes_q   <= '0;
      flagReg_q  <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      cnt_q      <= cnt_d;
      ownerId_q  <= ownerId_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluSel_q   <= aluSel_d;
      rspValid_q <= rspValid_d;
      rspRes_q   <= rspRes_d;
      flagReg_q  <= flagReg_d;
    end
  end

  assign bus.alu_a     = aluA_q;
  assign bus.alu_b     = aluB_q;
  assign bus.alu_sel   = aluSel_q;
  assign bus.rsp_valid = rspValid_q;
  assign bus.rsp_id    = ownerId_q;
  assign bus.rsp_res   = rspRes_q;
  assign bus.flags_q   = flagReg_q;

endmodule
